regfile: RTL

- 32 x 64-bit architectural register file for the LEGv8 datapath; the storage stage directly upstream of the 32:1 64-bit read multiplexer.
- Holds register state in flip-flops with a 5:32 write decoder.
- Two 64-bit read ports, each built from one 32:1 64-bit mux instance driven by the stored array.
- X31 (XZR) is hardwired to zero; writes to it are discarded.

---
 rtl/regfile.sv | 103 ++++++++++
 1 files changed

// File: rtl/regfile.sv
// 32 x WIDTH architectural register file (LEGv8). X0..X30 live in flip-flops
// behind a one-hot write decoder; X31 (XZR) has no storage and reads as zero.
// Each read port is a 32:1 mux over the stored array, with an optional
// same-cycle write-to-read forward.

module regfile_mux32 #(
  parameter int WIDTH = 64
) (
  input  logic [31:0][WIDTH-1:0] data_i,
  input  logic [4:0]             sel_i,
  output logic [WIDTH-1:0]       data_o
);

  // Plain 32:1 selection of one register word
  always_comb begin
    data_o = data_i[sel_i];
  end

endmodule

module regfile #(
  parameter int WIDTH  = 64,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  localparam logic [4:0] XZR = 5'd31;

  logic [WIDTH-1:0]       regs_q [0:30];
  logic [WIDTH-1:0]       regs_d [0:30];
  logic [30:0]            wr_en;
  logic [31:0][WIDTH-1:0] rd_bus;
  logic [WIDTH-1:0]       mux1_data;
  logic [WIDTH-1:0]       mux2_data;
  logic                   fwd1;
  logic                   fwd2;

  // One-hot write decoder; index 31 matches no slot, so XZR writes vanish
  for (genvar gi = 0; gi < 31; gi++) begin : g_dec
    assign wr_en[gi] = RegWrite && (WriteRegister == 5'(gi));
  end

  // Enable-mux in front of every register: hold unless selected
  always_comb begin
    for (int i = 0; i < 31; i++) begin
      regs_d[i] = wr_en[i] ? WriteData : regs_q[i];
    end
  end

  // Register storage, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 31; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 31; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Present the stored array plus a constant-zero XZR slot to the read muxes
  always_comb begin
    rd_bus = '0;
    for (int i = 0; i < 31; i++) begin
      rd_bus[i] = regs_q[i];
    end
  end

  regfile_mux32 #(.WIDTH(WIDTH)) u_mux1 (
    .data_i (rd_bus),
    .sel_i  (ReadRegister1),
    .data_o (mux1_data)
  );

  regfile_mux32 #(.WIDTH(WIDTH)) u_mux2 (
    .data_i (rd_bus),
    .sel_i  (ReadRegister2),
    .data_o (mux2_data)
  );

  // Forward a pending write to a matching read port; suppressed during reset
  // so both ports read zero while reset is held, and never for XZR
  always_comb begin
    fwd1 = BYPASS && !reset && RegWrite &&
           (WriteRegister == ReadRegister1) && (ReadRegister1 != XZR);
    fwd2 = BYPASS && !reset && RegWrite &&
           (WriteRegister == ReadRegister2) && (ReadRegister2 != XZR);
    ReadData1 = fwd1 ? WriteData : mux1_data;
    ReadData2 = fwd2 ? WriteData : mux2_data;
  end

endmodule
